// File: rtl/row_extent_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : row_extent_scanner_pkg
// Description : Shared types and address helper for the row extent scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package row_extent_scanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_R_ISSUE  = 3'd1,
        ST_R_WAIT   = 3'd2,
        ST_L_ISSUE  = 3'd3,
        ST_L_WAIT   = 3'd4,
        ST_NEXT_ROW = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    function automatic logic [31:0] pix_addr(input logic [31:0] y,
                                             input logic [31:0] x,
                                             input logic [31:0] img_w);
        return y * img_w + x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/row_extent_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : row_extent_scanner_if
// Description : Request/result handshake and pixel read port of the scanner.
// Revision    : 1.0 - initial release
// ============================================================================
interface row_extent_scanner_if #(
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int ADDR_W = 15,
    parameter int PIX_W  = 3
);
    logic              start;
    logic [Y_W-1:0]    top;
    logic [Y_W-1:0]    bottom;
    logic [X_W-1:0]    seed_x;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [X_W-1:0]    most_left;
    logic [X_W-1:0]    most_right;

    modport slave (
        input  start, top, bottom, seed_x, rd_data,
        output rd_en, rd_addr, busy, done, err, most_left, most_right
    );

    modport master (
        output start, top, bottom, seed_x, rd_data,
        input  rd_en, rd_addr, busy, done, err, most_left, most_right
    );
endinterface
`default_nettype wire

// File: rtl/row_extent_scanner_scan_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : scan_addr_gen
// Description : Combinational pixel address y*IMG_W + x, zero-extended operands.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_addr_gen
    import row_extent_scanner_pkg::*;
#(
    parameter int XA_W   = 9,
    parameter int Y_W    = 7,
    parameter int ADDR_W = 15,
    parameter int IMG_W  = 160
)(
    input  wire [Y_W-1:0]     i_y,
    input  wire [XA_W-1:0]    i_x,
    output logic [ADDR_W-1:0] o_addr
);
    assign o_addr = ADDR_W'(pix_addr(32'(i_y), 32'(i_x), 32'(IMG_W)));
endmodule
`default_nettype wire

// File: rtl/row_extent_scanner.sv
`default_nettype none
// ============================================================================
// Module      : row_extent_scanner
// Description : Finds leftmost/rightmost foreground column over rows top..bottom.
// Revision    : 1.0 - initial release
// ============================================================================
module row_extent_scanner
    import row_extent_scanner_pkg::*;
#(
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int ADDR_W    = 15,
    parameter int PIX_W     = 3,
    parameter int IMG_W     = 160,
    parameter int IMG_H     = 120,
    parameter int THRESHOLD = 0
)(
    input  wire                  clk,
    input  wire                  resetn,
    row_extent_scanner_if.slave  bus
);
    localparam logic [X_W:0]     c_X_MAX  = (X_W+1)'(IMG_W - 1);
    localparam logic [X_W:0]     c_X_LIM  = (X_W+1)'(IMG_W);
    localparam logic [Y_W:0]     c_Y_LIM  = (Y_W+1)'(IMG_H);
    localparam logic [PIX_W-1:0] c_THRESH = PIX_W'(THRESHOLD);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [Y_W-1:0]    r_y;
    logic [Y_W-1:0]    r_bottom;
    logic [X_W-1:0]    r_seed;
    logic [X_W:0]      r_x_r;
    logic [X_W:0]      r_x_l;
    logic [X_W-1:0]    r_left;
    logic [X_W-1:0]    r_right;
    logic              r_err;

    logic              w_rd_en;
    dir_e              w_dir;
    logic [X_W:0]      w_xr_nxt;
    logic [X_W:0]      w_xl_nxt;
    logic [X_W:0]      w_x;
    logic [ADDR_W-1:0] w_addr;
    logic              w_fg;
    logic              w_full;
    logic              w_req_bad;

    assign w_xr_nxt = r_x_r + 1'b1;
    assign w_xl_nxt = r_x_l - 1'b1;
    assign w_x      = (w_dir == DIR_LEFT) ? w_xl_nxt : w_xr_nxt;
    assign w_fg     = (bus.rd_data > c_THRESH);
    assign w_full   = (r_left == '0) && ({1'b0, r_right} == c_X_MAX);

    assign w_req_bad = (bus.top > bus.bottom)
                    || ({1'b0, bus.bottom} >= c_Y_LIM)
                    || ({1'b0, bus.seed_x} >= c_X_LIM);

    scan_addr_gen #(
        .XA_W   (X_W + 1),
        .Y_W    (Y_W),
        .ADDR_W (ADDR_W),
        .IMG_W  (IMG_W)
    ) u_addr_gen (
        .i_y    (r_y),
        .i_x    (w_x),
        .o_addr (w_addr)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Issue states bail out to DONE as soon as the extents span the whole image.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_dir       = DIR_RIGHT;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = w_req_bad ? ST_DONE : ST_R_ISSUE;
                end
            end
            ST_R_ISSUE: begin
                if (w_full) begin
                    w_state_nxt = ST_DONE;
                end else if (r_x_r == c_X_MAX) begin
                    w_state_nxt = ST_L_ISSUE;
                end else begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = ST_R_WAIT;
                end
            end
            ST_R_WAIT: begin
                w_state_nxt = w_fg ? ST_R_ISSUE : ST_L_ISSUE;
            end
            ST_L_ISSUE: begin
                w_dir = DIR_LEFT;
                if (w_full) begin
                    w_state_nxt = ST_DONE;
                end else if (r_x_l == '0) begin
                    w_state_nxt = ST_NEXT_ROW;
                end else begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = ST_L_WAIT;
                end
            end
            ST_L_WAIT: begin
                w_dir       = DIR_LEFT;
                w_state_nxt = w_fg ? ST_L_ISSUE : ST_NEXT_ROW;
            end
            ST_NEXT_ROW: begin
                w_state_nxt = (w_full || (r_y == r_bottom)) ? ST_DONE : ST_R_ISSUE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_y      <= '0;
            r_bottom <= '0;
            r_seed   <= '0;
            r_x_r    <= '0;
            r_x_l    <= '0;
            r_left   <= '0;
            r_right  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_y      <= bus.top;
                        r_bottom <= bus.bottom;
                        r_seed   <= bus.seed_x;
                        r_x_r    <= {1'b0, bus.seed_x};
                        r_x_l    <= {1'b0, bus.seed_x};
                        r_left   <= bus.seed_x;
                        r_right  <= bus.seed_x;
                        r_err    <= w_req_bad;
                    end
                end
                ST_R_WAIT: begin
                    if (w_fg) begin
                        r_x_r <= w_xr_nxt;
                        if (w_xr_nxt > {1'b0, r_right}) begin
                            r_right <= w_xr_nxt[X_W-1:0];
                        end
                    end
                end
                ST_L_WAIT: begin
                    if (w_fg) begin
                        r_x_l <= w_xl_nxt;
                        if (w_xl_nxt < {1'b0, r_left}) begin
                            r_left <= w_xl_nxt[X_W-1:0];
                        end
                    end
                end
                ST_NEXT_ROW: begin
                    // Each row restarts from the seed column, which is assumed foreground.
                    if (r_y != r_bottom) begin
                        r_y   <= r_y + 1'b1;
                        r_x_r <= {1'b0, r_seed};
                        r_x_l <= {1'b0, r_seed};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rd_en      = w_rd_en;
    assign bus.rd_addr    = w_rd_en ? w_addr : '0;
    assign bus.busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.err        = (r_state == ST_DONE) && r_err;
    assign bus.most_left  = r_left;
    assign bus.most_right = r_right;

endmodule
`default_nettype wire

// File: tb/tb_row_extent_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_row_extent_scanner
// Description : Directed self-checking bench for row_extent_scanner (16x8 image).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_row_extent_scanner;
    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int ADDR_W = 7;
    localparam int PIX_W  = 3;
    localparam int IMG_W  = 16;
    localparam int IMG_H  = 8;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    row_extent_scanner_if #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

    row_extent_scanner #(
        .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .PIX_W(PIX_W),
        .IMG_W(IMG_W), .IMG_H(IMG_H), .THRESHOLD(0)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    logic [PIX_W-1:0] mem [0:IMG_W*IMG_H-1];

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    int rd_cnt    = 0;
    int rd_hi_cnt = 0;
    int done_cnt  = 0;
    int checks    = 0;
    int failures  = 0;

    always @(posedge clk) begin
        if (bus.rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (bus.rd_addr >= 7'd32) rd_hi_cnt <= rd_hi_cnt + 1;
        end
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < IMG_W*IMG_H; i++) mem[i] = '0;
    endtask

    task automatic fill(input int y, input int x0, input int x1, input logic [PIX_W-1:0] v);
        for (int x = x0; x <= x1; x++) mem[y*IMG_W + x] = v;
    endtask

    task automatic run(input logic [Y_W-1:0] t, input logic [Y_W-1:0] b,
                       input logic [X_W-1:0] s, output int cyc, output bit got,
                       output logic busy1, output int reads);
        int r0;
        r0 = rd_cnt;
        bus.top = t; bus.bottom = b; bus.seed_x = s; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        busy1 = bus.busy;
        cyc = 1;
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            cyc++;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        reads = rd_cnt - r0;
    endtask

    int   cyc, reads, d0, h0;
    bit   got;
    logic busy1;

    initial begin
        bus.start = 1'b0; bus.top = '0; bus.bottom = '0; bus.seed_x = '0;
        clear_mem();
        repeat (3) tick();
        chk("rst_busy",  bus.busy, 0);
        chk("rst_done",  bus.done, 0);
        chk("rst_err",   bus.err, 0);
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_addr",  bus.rd_addr, 0);
        chk("rst_left",  bus.most_left, 0);
        chk("rst_right", bus.most_right, 0);
        resetn = 1'b1;
        tick();

        // Rectangle x5..9, rows 2..4
        fill(2, 5, 9, 3'd1); fill(3, 5, 9, 3'd1); fill(4, 5, 9, 3'd1);
        run(7'd2, 7'd4, 8'd7, cyc, got, busy1, reads);
        chk("rect_done",  got, 1);
        chk("rect_busy",  busy1, 1);
        chk("rect_err",   bus.err, 0);
        chk("rect_left",  bus.most_left, 5);
        chk("rect_right", bus.most_right, 9);
        chk("rect_reads", reads, 18);
        chk("rect_cyc",   cyc, 41);
        tick();
        chk("rect_done_pulse", bus.done, 0);
        chk("rect_hold_left",  bus.most_left, 5);

        // Diamond
        clear_mem();
        fill(3, 6, 8, 3'd7); fill(4, 4, 10, 3'd7); fill(5, 6, 8, 3'd7);
        run(7'd3, 7'd5, 8'd7, cyc, got, busy1, reads);
        chk("dia_done",  got, 1);
        chk("dia_left",  bus.most_left, 4);
        chk("dia_right", bus.most_right, 10);
        chk("dia_reads", reads, 16);
        chk("dia_cyc",   cyc, 37);
        tick();

        // Full-width row 1 triggers early exit
        clear_mem();
        fill(1, 0, 15, 3'd2); fill(2, 3, 12, 3'd2);
        h0 = rd_hi_cnt;
        run(7'd1, 7'd6, 8'd8, cyc, got, busy1, reads);
        chk("full_done",  got, 1);
        chk("full_left",  bus.most_left, 0);
        chk("full_right", bus.most_right, 15);
        chk("full_reads", reads, 15);
        chk("full_hi",    rd_hi_cnt - h0, 0);
        tick();

        // Invalid requests
        run(7'd5, 7'd2, 8'd3, cyc, got, busy1, reads);
        chk("inv_done",  got, 1);
        chk("inv_cyc",   cyc, 2);
        chk("inv_err",   bus.err, 1);
        chk("inv_busy",  busy1, 0);
        chk("inv_left",  bus.most_left, 3);
        chk("inv_right", bus.most_right, 3);
        chk("inv_reads", reads, 0);
        tick();
        chk("inv_err_clr", bus.err, 0);
        run(7'd2, 7'd8, 8'd4, cyc, got, busy1, reads);
        chk("inv_bot_err", bus.err, 1);
        tick();
        run(7'd0, 7'd7, 8'd16, cyc, got, busy1, reads);
        chk("inv_seed_err",  bus.err, 1);
        chk("inv_seed_left", bus.most_left, 16);
        tick();

        // Start during scan and coincident with done are ignored
        clear_mem();
        fill(2, 5, 9, 3'd1); fill(3, 5, 9, 3'd1); fill(4, 5, 9, 3'd1);
        d0 = done_cnt;
        bus.top = 7'd2; bus.bottom = 7'd4; bus.seed_x = 8'd7; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        bus.top = 7'd0; bus.bottom = 7'd0; bus.seed_x = 8'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("busy_start_done",  got, 1);
        chk("busy_start_left",  bus.most_left, 5);
        chk("busy_start_right", bus.most_right, 9);
        bus.top = 7'd3; bus.bottom = 7'd3; bus.seed_x = 8'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("done_start_busy", bus.busy, 0);
        repeat (3) tick();
        chk("done_start_count", done_cnt - d0, 1);
        chk("done_start_left",  bus.most_left, 5);

        // Reset mid-row
        d0 = done_cnt;
        bus.top = 7'd2; bus.bottom = 7'd4; bus.seed_x = 8'd7; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        resetn = 1'b0;
        #1;
        chk("mid_rst_busy",  bus.busy, 0);
        chk("mid_rst_rd_en", bus.rd_en, 0);
        chk("mid_rst_addr",  bus.rd_addr, 0);
        chk("mid_rst_left",  bus.most_left, 0);
        chk("mid_rst_right", bus.most_right, 0);
        repeat (3) tick();
        resetn = 1'b1;
        repeat (50) tick();
        chk("mid_rst_no_done", done_cnt - d0, 0);

        // Single pixel
        clear_mem();
        fill(3, 3, 3, 3'd4);
        run(7'd3, 7'd3, 8'd3, cyc, got, busy1, reads);
        chk("px_done",  got, 1);
        chk("px_left",  bus.most_left, 3);
        chk("px_right", bus.most_right, 3);
        chk("px_reads", reads, 2);
        chk("px_cyc",   cyc, 7);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
